// File: rtl/simple_dp_ram_ex_if.sv
// Bus bundle for simple_dp_ram_ex: a byte-masked write port, a read port and
// the status outputs.
//   master : drives ena/wea/addra/dina and enb/addrb; observes doutb, doutb_valid, init_done
//   slave  : the RAM side of the same signals
interface simple_dp_ram_ex_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned BYTE_WIDTH = 8
);
  localparam int unsigned NB = DATA_WIDTH / BYTE_WIDTH;

  logic                  ena;
  logic [NB-1:0]         wea;
  logic [ADDR_WIDTH-1:0] addra;
  logic [DATA_WIDTH-1:0] dina;
  logic                  enb;
  logic [ADDR_WIDTH-1:0] addrb;
  logic [DATA_WIDTH-1:0] doutb;
  logic                  doutb_valid;
  logic                  init_done;

  modport master (
    output ena, wea, addra, dina, enb, addrb,
    input  doutb, doutb_valid, init_done
  );

  modport slave (
    input  ena, wea, addra, dina, enb, addrb,
    output doutb, doutb_valid, init_done
  );
endinterface

// File: rtl/simple_dp_ram_ex.sv
// Simple dual-port RAM: one byte-masked write port and one read port on a
// single clock. After reset the array is optionally zero-filled by a CLEAR
// sweep before the ports are opened (init_done).
//   clk, rst_n : clock and synchronous active-low reset
//   ram_if     : slave side of simple_dp_ram_ex_if (write port, read port,
//                doutb/doutb_valid read result, init_done status)
// Parameters: OUT_REG adds a second read stage; RDW_MODE selects old (0) or
// merged new (1) data on a same-address read/write collision.
module simple_dp_ram_ex #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned BYTE_WIDTH     = 8,
  parameter int unsigned OUT_REG        = 0,
  parameter int unsigned RDW_MODE       = 0,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  simple_dp_ram_ex_if.slave  ram_if
);
  localparam int unsigned NB    = DATA_WIDTH / BYTE_WIDTH;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_CLEAR = 2'd1,
    ST_READY = 2'd2
  } state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] clr_cnt_q;
  logic                  init_done_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  wr_fire_c;
  logic                  rd_fire_c;
  logic [DATA_WIDTH-1:0] rd_word_c;

  logic [DATA_WIDTH-1:0] s1_data_q;
  logic                  s1_valid_q;
  logic [DATA_WIDTH-1:0] doutb_q;
  logic                  doutb_valid_q;

  // Control FSM: RST -> (CLEAR ->) READY; the clear counter holds at its last
  // address rather than wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_RST;
      clr_cnt_q   <= '0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RST: begin
          if (CLEAR_ON_RESET != 0) begin
            state_q <= ST_CLEAR;
          end else begin
            state_q     <= ST_READY;
            init_done_q <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (clr_cnt_q == '1) begin
            state_q     <= ST_READY;
            init_done_q <= 1'b1;
          end else begin
            clr_cnt_q <= clr_cnt_q + ADDR_WIDTH'(1);
          end
        end
        ST_READY: begin
          state_q <= ST_READY;
        end
        default: begin
          state_q <= ST_RST;
        end
      endcase
    end
  end

  // User ports are only honoured in READY and never on a reset edge.
  assign wr_fire_c = rst_n && (state_q == ST_READY) && ram_if.ena;
  assign rd_fire_c = rst_n && (state_q == ST_READY) && ram_if.enb;

  // Array write: CLEAR sweep zeroes one word per cycle, otherwise byte-masked user write.
  always_ff @(posedge clk) begin
    if (rst_n && (state_q == ST_CLEAR)) begin
      mem[clr_cnt_q] <= '0;
    end else if (wr_fire_c) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (ram_if.wea[i]) begin
          mem[ram_if.addra][i*BYTE_WIDTH +: BYTE_WIDTH] <= ram_if.dina[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // Read word; in new-data mode a same-address write is forwarded lane by lane.
  always_comb begin
    rd_word_c = mem[ram_if.addrb];
    if ((RDW_MODE != 0) && wr_fire_c && (ram_if.addra == ram_if.addrb)) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (ram_if.wea[i]) begin
          rd_word_c[i*BYTE_WIDTH +: BYTE_WIDTH] = ram_if.dina[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // Read pipeline: one or two stages; doutb only changes when a read completes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_data_q     <= '0;
      s1_valid_q    <= 1'b0;
      doutb_q       <= '0;
      doutb_valid_q <= 1'b0;
    end else if (OUT_REG != 0) begin
      s1_valid_q    <= rd_fire_c;
      doutb_valid_q <= s1_valid_q;
      if (rd_fire_c) begin
        s1_data_q <= rd_word_c;
      end
      if (s1_valid_q) begin
        doutb_q <= s1_data_q;
      end
    end else begin
      s1_valid_q    <= 1'b0;
      doutb_valid_q <= rd_fire_c;
      if (rd_fire_c) begin
        doutb_q <= rd_word_c;
      end
    end
  end

  assign ram_if.doutb       = doutb_q;
  assign ram_if.doutb_valid = doutb_valid_q;
  assign ram_if.init_done   = init_done_q;

endmodule

// File: tb/tb_simple_dp_ram_ex.sv
// Directed bench for simple_dp_ram_ex with ADDR_WIDTH=4. Three instances share
// one stimulus stream:
//   u_a : OUT_REG=0, RDW_MODE=0, CLEAR_ON_RESET=1
//   u_b : OUT_REG=1, RDW_MODE=1, CLEAR_ON_RESET=1
//   u_c : OUT_REG=0, RDW_MODE=0, CLEAR_ON_RESET=0
module tb_simple_dp_ram_ex;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;
  localparam int unsigned NB = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ena;
  logic [NB-1:0] wea;
  logic [AW-1:0] addra;
  logic [DW-1:0] dina;
  logic          enb;
  logic [AW-1:0] addrb;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  simple_dp_ram_ex_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(8)) ifa ();
  simple_dp_ram_ex_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(8)) ifb ();
  simple_dp_ram_ex_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(8)) ifc ();

  assign ifa.ena = ena;  assign ifa.wea = wea;  assign ifa.addra = addra;
  assign ifa.dina = dina; assign ifa.enb = enb; assign ifa.addrb = addrb;
  assign ifb.ena = ena;  assign ifb.wea = wea;  assign ifb.addra = addra;
  assign ifb.dina = dina; assign ifb.enb = enb; assign ifb.addrb = addrb;
  assign ifc.ena = ena;  assign ifc.wea = wea;  assign ifc.addra = addra;
  assign ifc.dina = dina; assign ifc.enb = enb; assign ifc.addrb = addrb;

  simple_dp_ram_ex #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(8),
    .OUT_REG(0), .RDW_MODE(0), .CLEAR_ON_RESET(1)) u_a (.clk(clk), .rst_n(rst_n), .ram_if(ifa));
  simple_dp_ram_ex #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(8),
    .OUT_REG(1), .RDW_MODE(1), .CLEAR_ON_RESET(1)) u_b (.clk(clk), .rst_n(rst_n), .ram_if(ifb));
  simple_dp_ram_ex #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(8),
    .OUT_REG(0), .RDW_MODE(0), .CLEAR_ON_RESET(0)) u_c (.clk(clk), .rst_n(rst_n), .ram_if(ifc));

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Contents of addresses 0..7 after the write pattern below.
  function automatic logic [31:0] exp_pat(input int i);
    if (i == 3) return 32'hDEAD12EF;
    return 32'hA000_0000 | 32'(i);
  endfunction

  initial begin
    rst_n = 1'b0; ena = 1'b0; wea = '0; addra = '0; dina = '0; enb = 1'b0; addrb = '0;
    repeat (3) tick();
    check_eq("rst_a_dout", ifa.doutb, 32'h0);
    check_eq("rst_a_vld",  32'(ifa.doutb_valid), 32'h0);
    check_eq("rst_a_init", 32'(ifa.init_done), 32'h0);
    check_eq("rst_b_dout", ifb.doutb, 32'h0);
    check_eq("rst_c_init", 32'(ifc.init_done), 32'h0);

    // First release: edge 0 leaves RST; C is usable straight away.
    rst_n = 1'b1;
    tick();
    check_eq("c_init_first", 32'(ifc.init_done), 32'h1);
    check_eq("a_init_first", 32'(ifa.init_done), 32'h0);
    ena = 1'b1; wea = 4'hF; addra = 4'd7; dina = 32'hCAFEF00D;
    tick();
    ena = 1'b0;
    // Edges 2..9 take A/B's clear counter to 9, then reset mid-CLEAR.
    repeat (8) tick();
    check_eq("a_init_midclr", 32'(ifa.init_done), 32'h0);
    rst_n = 1'b0;
    tick();
    check_eq("a_init_rst2", 32'(ifa.init_done), 32'h0);
    check_eq("c_init_rst2", 32'(ifc.init_done), 32'h0);
    tick();

    // Second release with enb held high: edge 0 enters CLEAR, edges 1..16
    // sweep addresses 0..15, READY (init_done) is seen after edge 16.
    rst_n = 1'b1; enb = 1'b1; addrb = 4'd0;
    for (int k = 0; k <= 16; k++) begin
      tick();
      check_eq("a_init_clr", 32'(ifa.init_done), (k == 16) ? 32'h1 : 32'h0);
      check_eq("a_vld_clr",  32'(ifa.doutb_valid), 32'h0);
      check_eq("b_vld_clr",  32'(ifb.doutb_valid), 32'h0);
    end
    enb = 1'b0;
    tick();

    // Sweep every address: all zero on A and B; C keeps its word at 7.
    for (int j = 0; j <= 16; j++) begin
      enb = (j < 16); addrb = AW'(j);
      tick();
      if (j < 16) begin
        check_eq("a_zero_vld", 32'(ifa.doutb_valid), 32'h1);
        check_eq("a_zero_dat", ifa.doutb, 32'h0);
      end else begin
        check_eq("a_zero_end", 32'(ifa.doutb_valid), 32'h0);
      end
      if (j >= 1) begin
        check_eq("b_zero_vld", 32'(ifb.doutb_valid), 32'h1);
        check_eq("b_zero_dat", ifb.doutb, 32'h0);
      end
      if (j == 7) check_eq("c_word7", ifc.doutb, 32'hCAFEF00D);
    end
    enb = 1'b0;
    repeat (2) tick();

    // Fill 0..7, then full and single-lane writes to address 3.
    for (int i = 0; i < 8; i++) begin
      ena = 1'b1; wea = 4'hF; addra = AW'(i); dina = 32'hA000_0000 | 32'(i);
      tick();
    end
    addra = 4'd3; dina = 32'hDEADBEEF; tick();
    wea = 4'b0010; dina = 32'h0000_1200; tick();
    ena = 1'b0; wea = '0;
    repeat (3) tick();

    // Back-to-back reads of 0..7: A valid after edges 0..7, B after 1..8.
    for (int j = 0; j <= 9; j++) begin
      enb = (j < 8); addrb = AW'(j);
      tick();
      check_eq("a_strm_vld", 32'(ifa.doutb_valid), (j < 8) ? 32'h1 : 32'h0);
      if (j < 8) check_eq("a_strm_dat", ifa.doutb, exp_pat(j));
      else       check_eq("a_strm_hold", ifa.doutb, exp_pat(7));
      check_eq("b_strm_vld", 32'(ifb.doutb_valid), (j >= 1 && j <= 8) ? 32'h1 : 32'h0);
      if (j >= 1 && j <= 8) check_eq("b_strm_dat", ifb.doutb, exp_pat(j - 1));
      else if (j == 9)      check_eq("b_strm_hold", ifb.doutb, exp_pat(7));
    end
    enb = 1'b0;
    tick();

    // Same-address collision on address 5.
    ena = 1'b1; wea = 4'hF; addra = 4'd5; dina = 32'h11111111;
    tick();
    wea = 4'b0011; dina = 32'h22222222; enb = 1'b1; addrb = 4'd5;
    tick();
    ena = 1'b0; enb = 1'b0; wea = '0;
    check_eq("a_rdw_vld", 32'(ifa.doutb_valid), 32'h1);
    check_eq("a_rdw_old", ifa.doutb, 32'h11111111);
    tick();
    check_eq("b_rdw_vld", 32'(ifb.doutb_valid), 32'h1);
    check_eq("b_rdw_new", ifb.doutb, 32'h11112222);
    enb = 1'b1; addrb = 4'd5;
    tick();
    enb = 1'b0;
    check_eq("a_after_rdw", ifa.doutb, 32'h11112222);

    // Write 6 and read 4 in the same cycle: independent.
    ena = 1'b1; wea = 4'hF; addra = 4'd6; dina = 32'h66666666; enb = 1'b1; addrb = 4'd4;
    tick();
    ena = 1'b0; wea = '0; enb = 1'b0;
    check_eq("a_diff_rd", ifa.doutb, 32'hA0000004);
    tick();
    check_eq("b_diff_rd", ifb.doutb, 32'hA0000004);
    enb = 1'b1; addrb = 4'd6;
    tick();
    enb = 1'b0;
    check_eq("a_diff_wr", ifa.doutb, 32'h66666666);
    tick();

    // Reset while B holds a read in its first stage.
    enb = 1'b1; addrb = 4'd6;
    tick();
    enb = 1'b0; rst_n = 1'b0;
    tick();
    check_eq("b_rst_vld",  32'(ifb.doutb_valid), 32'h0);
    check_eq("b_rst_dout", ifb.doutb, 32'h0);
    check_eq("a_rst_dout", ifa.doutb, 32'h0);
    check_eq("a_rst_init", 32'(ifa.init_done), 32'h0);
    rst_n = 1'b1;
    tick();
    check_eq("b_post_rst_vld0", 32'(ifb.doutb_valid), 32'h0);
    enb = 1'b1; addrb = 4'd6;
    tick();
    enb = 1'b0;
    check_eq("b_post_rst_vld1", 32'(ifb.doutb_valid), 32'h0);
    check_eq("c_keep_vld", 32'(ifc.doutb_valid), 32'h1);
    check_eq("c_keep_dat", ifc.doutb, 32'h66666666);
    tick();
    check_eq("b_post_rst_vld2", 32'(ifb.doutb_valid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/simple_dp_ram_ex.md
SIMPLE_DP_RAM_EX -- requirements
Module: simple_dp_ram_ex

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- DATA_WIDTH, 32, word width in bits; must be a multiple of BYTE_WIDTH.
- ADDR_WIDTH, 10, address width; depth DEPTH = 2**ADDR_WIDTH words, exactly.
- BYTE_WIDTH, 8, byte-lane width; NB = DATA_WIDTH/BYTE_WIDTH lanes.
- OUT_REG, 0, 0 gives 1-cycle read latency; 1 adds an output register for 2-cycle latency.
- RDW_MODE, 0, read-during-write to the same address: 0 returns old data, 1 returns new (merged) data.
- CLEAR_ON_RESET, 1, 1 zero-fills the array after reset; 0 skips the fill.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, single clock for both ports.
- rst_n, in, 1, synchronous active-low reset.
- ena, in, 1, write-port enable.
- wea, in, NB, per-byte write enable; bit i writes dina lane i.
- addra, in, ADDR_WIDTH, write address.
- dina, in, DATA_WIDTH, write data.
- enb, in, 1, read enable.
- addrb, in, ADDR_WIDTH, read address.
- doutb, out, DATA_WIDTH, read data.
- doutb_valid, out, 1, one-cycle pulse marking a new doutb.
- init_done, out, 1, high when the array is usable.

REQ-003 The block SHALL have one clock and a synchronous, active-low reset (rst_n sampled on the rising edge of clk).

Function
REQ-004 The control FSM SHALL have three states: RST, CLEAR and READY.
REQ-005 While rst_n=0, the FSM SHALL be in RST with the clear counter at 0.
REQ-006 On the first clock with rst_n=1, the FSM SHALL go from RST to CLEAR when CLEAR_ON_RESET=1, otherwise to READY.
REQ-007 In CLEAR, the block SHALL write all-zero to address clr_cnt each cycle and increment clr_cnt, from 0 to DEPTH-1, taking exactly DEPTH cycles.
REQ-008 When clr_cnt=DEPTH-1 is written, the FSM SHALL move to READY on the next edge, and clr_cnt SHALL not wrap.
REQ-009 init_done SHALL be 1 only in READY; it SHALL rise on the first READY cycle and stay high until reset.
REQ-010 Outside READY, ena and enb SHALL be ignored: no user write, no read, doutb_valid=0.
REQ-011 Write: in READY, with ena=1, byte lane i of mem[addra] SHALL take dina lane i at the edge for each wea[i]=1; other lanes SHALL be unchanged.
REQ-012 ena=1 with wea=0 SHALL be a no-op.
REQ-013 Read, OUT_REG=0: enb=1 in READY at edge T SHALL give doutb=mem[addrb] and doutb_valid=1 for the cycle after edge T.
REQ-014 Read, OUT_REG=1: the same read SHALL appear one cycle later, after edge T+1, with doutb_valid aligned to it.
REQ-015 Back-to-back reads SHALL sustain one word per cycle at either latency.
REQ-016 When no new read completes, doutb SHALL hold its last value and doutb_valid SHALL be 0.
REQ-017 Collision (ena=1, enb=1, addra=addrb, same edge), RDW_MODE=0: the read SHALL return the pre-write word.
REQ-018 Collision, RDW_MODE=1: the read SHALL return written lanes from dina and the remaining lanes from the old word.
REQ-019 Writes and reads to different addresses in the same cycle SHALL not interact.
REQ-020 Addresses SHALL be used modulo DEPTH; no out-of-range storage exists.

Reset
REQ-021 rst_n=0 SHALL force doutb=0, doutb_valid=0, init_done=0, FSM=RST and clr_cnt=0 at the next edge, including mid-CLEAR and mid-read.
REQ-022 Reads in the OUT_REG pipeline at reset SHALL be discarded, with no valid pulse after reset.
REQ-023 Reset SHALL not clear array contents directly; zeroing happens only through CLEAR.
REQ-024 Reset mid-CLEAR SHALL restart CLEAR from address 0 after release.

Verification
REQ-025 ADDR_WIDTH=4, CLEAR_ON_RESET=1, rst_n released at cycle 0: init_done SHALL rise after exactly 16 CLEAR cycles; every address SHALL then read 0x00000000; enb pulses during CLEAR SHALL give no doutb_valid.
REQ-026 Write 0xDEADBEEF to address 3 with wea=4'b1111, then wea=4'b0010 with dina=0x00001200: a read of address 3 SHALL return 0xDEAD12EF.
REQ-027 OUT_REG=0 and OUT_REG=1, reads of addresses 0..7 on consecutive cycles: eight consecutive valid pulses, in order, starting 1 or 2 cycles after the first enb respectively.
REQ-028 Address 5 holds 0x11111111; same-cycle write of 0x22222222 with wea=4'b0011 and read of address 5: the read SHALL return 0x11111111 for RDW_MODE=0 and 0x11112222 for RDW_MODE=1.
REQ-029 Assert rst_n=0 at clr_cnt=9, then release: CLEAR SHALL restart at 0 and init_done SHALL rise 16 cycles after release.
REQ-030 CLEAR_ON_RESET=0: init_done=1 on the first cycle after release; a write SHALL be accepted that same cycle.
